// File: rtl/derivative_buffer_ctrl.sv
// rtl/derivative_buffer_ctrl.sv - derivative buffer RAM sequencer for one RS(255) decoder lane
// Writes one frame of N_SYM symbols, then replays it in address order while the next frame refills read slots.
module derivative_buffer_ctrl #(
  parameter int N_SYM = 255,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic          out_sof,
  output logic          out_eof,
  output logic [DW-1:0] out_data,
  output logic          frame_err,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic [AW-1:0] ram_wraddress,
  output logic          ram_rden,
  output logic [AW-1:0] ram_rdaddress,
  input  logic [DW-1:0] ram_q
);

  typedef enum logic {R_IDLE, R_RUN} rd_state_t;

  localparam logic [AW-1:0] LAST = AW'(N_SYM - 1);

  rd_state_t     state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          full_q, full_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eof_q, out_eof_d;
  logic          frame_err_q, frame_err_d;
  logic          rd_active;

  assign rd_active = (state_q == R_RUN);
  // Overlapped writes may only land on addresses the current frame has already read.
  assign in_ready  = !full_q || (rd_active && (wr_cnt_q < rd_cnt_q));

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign frame_err = frame_err_q;
  assign out_data  = out_valid_q ? ram_q : '0;

  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    rd_cnt_d      = rd_cnt_q;
    full_d        = full_q;
    out_valid_d   = 1'b0;
    out_sof_d     = 1'b0;
    out_eof_d     = 1'b0;
    frame_err_d   = 1'b0;
    ram_wren      = 1'b0;
    ram_wraddress = '0;
    ram_data      = '0;
    ram_rden      = 1'b0;
    ram_rdaddress = '0;

    if (in_valid && in_ready) begin
      if (in_sof) begin
        // A start-of-frame always restarts the frame at address 0.
        frame_err_d   = (wr_cnt_q != '0);
        ram_wren      = 1'b1;
        ram_data      = in_data;
        wr_cnt_d      = AW'(1);
      end else if (wr_cnt_q == '0) begin
        frame_err_d   = 1'b1;
      end else begin
        ram_wren      = 1'b1;
        ram_wraddress = wr_cnt_q;
        ram_data      = in_data;
        if (wr_cnt_q == LAST) begin
          wr_cnt_d = '0;
          full_d   = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + AW'(1);
        end
      end
    end

    case (state_q)
      R_IDLE: if (full_q) state_d = R_RUN;
      R_RUN: begin
        if (out_ready) begin
          ram_rden      = 1'b1;
          ram_rdaddress = rd_cnt_q;
          out_valid_d   = 1'b1;
          out_sof_d     = (rd_cnt_q == '0);
          out_eof_d     = (rd_cnt_q == LAST);
          if (rd_cnt_q == LAST) begin
            rd_cnt_d = '0;
            full_d   = 1'b0;
            state_d  = R_IDLE;
          end else begin
            rd_cnt_d = rd_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= R_IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      full_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_derivative_buffer_ctrl.sv
// tb/tb_derivative_buffer_ctrl.sv - scoreboard bench for derivative_buffer_ctrl
// Drives a 255-symbol lane and a 4-symbol lane, each with its own RAM model.
module tb_derivative_buffer_ctrl;
  localparam int N  = 255;
  localparam int NS = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       in_sof;
  logic [7:0] in_data;

  logic       in_valid, in_ready, out_ready, out_valid, out_sof, out_eof, frame_err, ram_wren, ram_rden;
  logic [7:0] out_data, ram_data, ram_q, ram_wraddress, ram_rdaddress;

  logic       s_in_valid, s_in_ready, s_out_ready, s_out_valid, s_out_sof, s_out_eof, s_frame_err;
  logic       s_ram_wren, s_ram_rden;
  logic [7:0] s_out_data, s_ram_data, s_ram_q;
  logic [1:0] s_ram_wraddress, s_ram_rdaddress;

  derivative_buffer_ctrl #(.N_SYM(N), .AW(8), .DW(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .out_sof(out_sof),
    .out_eof(out_eof), .out_data(out_data), .frame_err(frame_err), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_wraddress(ram_wraddress), .ram_rden(ram_rden),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  derivative_buffer_ctrl #(.N_SYM(NS), .AW(2), .DW(8)) dut_s (
    .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_sof(in_sof), .in_data(in_data),
    .in_ready(s_in_ready), .out_ready(s_out_ready), .out_valid(s_out_valid), .out_sof(s_out_sof),
    .out_eof(s_out_eof), .out_data(s_out_data), .frame_err(s_frame_err), .ram_data(s_ram_data),
    .ram_wren(s_ram_wren), .ram_wraddress(s_ram_wraddress), .ram_rden(s_ram_rden),
    .ram_rdaddress(s_ram_rdaddress), .ram_q(s_ram_q)
  );

  logic [7:0] mem   [256];
  logic [7:0] s_mem [4];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    if (ram_rden) ram_q <= mem[ram_rdaddress];
    if (s_ram_wren) s_mem[s_ram_wraddress] <= s_ram_data;
    if (s_ram_rden) s_ram_q <= s_mem[s_ram_rdaddress];
  end

  int tests = 0;
  int fails = 0;
  int rx_main = 0, rx_small = 0, err_main = 0, rden_main = 0;
  logic [9:0] q_main[$];
  logic [9:0] q_small[$];
  bit rand_en = 0;

  always @(posedge clock) begin
    if (rand_en) begin
      #1;
      s_out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Main-lane monitor: read latency, readback order and overlap-write safety.
  logic       m_prev_rden = 0, m_reading = 0;
  int         m_rd_cnt = 0;
  logic [9:0] m_exp;
  always @(negedge clock) begin
    if (!reset_n) begin
      q_main.delete();
      m_prev_rden = 0; m_reading = 0; m_rd_cnt = 0;
    end else begin
      if (m_prev_rden || out_valid) begin
        tests++;
        if (out_valid !== m_prev_rden) begin
          fails++; $display("FAIL main_rden_to_valid: out_valid=%b required %b", out_valid, m_prev_rden);
        end
      end
      if (out_valid) begin
        rx_main++;
        tests++;
        if (q_main.size() == 0) begin
          fails++; $display("FAIL main_unexpected_output: got data=%h, none expected", out_data);
        end else begin
          m_exp = q_main.pop_front();
          if ({out_sof, out_eof, out_data} !== m_exp)
            begin fails++; $display("FAIL main_readback: sof/eof/data=%b/%b/%h required %b/%b/%h",
              out_sof, out_eof, out_data, m_exp[9], m_exp[8], m_exp[7:0]); end
        end
      end
      if (ram_wren && m_reading) begin
        tests++;
        if (!(int'(ram_wraddress) < m_rd_cnt)) begin
          fails++; $display("FAIL main_overlap_write: wraddress=%0d required < %0d", ram_wraddress, m_rd_cnt);
        end
      end
      if (ram_rden) begin
        rden_main++;
        tests++;
        if (ram_rdaddress !== 8'(m_rd_cnt)) begin
          fails++; $display("FAIL main_rd_order: rdaddress=%0d required %0d", ram_rdaddress, m_rd_cnt);
        end
        m_reading = (m_rd_cnt != N - 1);
        m_rd_cnt  = (m_rd_cnt == N - 1) ? 0 : m_rd_cnt + 1;
      end
      if (frame_err) err_main++;
      m_prev_rden = ram_rden;
    end
  end

  logic       s_prev_rden = 0, s_reading = 0;
  int         s_rd_cnt = 0;
  logic [9:0] s_exp;
  always @(negedge clock) begin
    if (!reset_n) begin
      q_small.delete();
      s_prev_rden = 0; s_reading = 0; s_rd_cnt = 0;
    end else begin
      if (s_prev_rden || s_out_valid) begin
        tests++;
        if (s_out_valid !== s_prev_rden) begin
          fails++; $display("FAIL small_rden_to_valid: out_valid=%b required %b", s_out_valid, s_prev_rden);
        end
      end
      if (s_out_valid) begin
        rx_small++;
        tests++;
        if (q_small.size() == 0) begin
          fails++; $display("FAIL small_unexpected_output: got data=%h, none expected", s_out_data);
        end else begin
          s_exp = q_small.pop_front();
          if ({s_out_sof, s_out_eof, s_out_data} !== s_exp)
            begin fails++; $display("FAIL small_readback: sof/eof/data=%b/%b/%h required %b/%b/%h",
              s_out_sof, s_out_eof, s_out_data, s_exp[9], s_exp[8], s_exp[7:0]); end
        end
      end
      if (s_ram_wren && s_reading) begin
        tests++;
        if (!(int'(s_ram_wraddress) < s_rd_cnt)) begin
          fails++; $display("FAIL small_overlap_write: wraddress=%0d required < %0d", s_ram_wraddress, s_rd_cnt);
        end
      end
      if (s_ram_rden) begin
        tests++;
        if (s_ram_rdaddress !== 2'(s_rd_cnt)) begin
          fails++; $display("FAIL small_rd_order: rdaddress=%0d required %0d", s_ram_rdaddress, s_rd_cnt);
        end
        s_reading = (s_rd_cnt != NS - 1);
        s_rd_cnt  = (s_rd_cnt == NS - 1) ? 0 : s_rd_cnt + 1;
      end
      s_prev_rden = s_ram_rden;
    end
  end

  task automatic send_sym(input bit sel, input logic [7:0] d, input bit sof, input bit exp_wren,
                          input int exp_addr, input bit push, input bit eof);
    int  t = 0;
    bit  done = 0;
    bit  ok;
    logic [1:0] a2;
    a2 = exp_addr[1:0];
    in_sof = sof; in_data = d;
    if (sel) s_in_valid = 1'b1; else in_valid = 1'b1;
    while (!done) begin
      @(negedge clock);
      if ((sel ? s_in_ready : in_ready) === 1'b1) begin
        tests++;
        if (sel) ok = (s_ram_wren === exp_wren) && (!exp_wren || (s_ram_wraddress === a2 && s_ram_data === d));
        else     ok = (ram_wren === exp_wren) && (!exp_wren || (ram_wraddress === 8'(exp_addr) && ram_data === d));
        if (!ok) begin
          fails++;
          $display("FAIL write_port: lane=%0d wren=%b addr=%0d data=%h required wren=%b addr=%0d data=%h", sel,
            sel ? s_ram_wren : ram_wren, sel ? 8'(s_ram_wraddress) : ram_wraddress,
            sel ? s_ram_data : ram_data, exp_wren, exp_addr, d);
        end
        if (push) begin
          if (sel) q_small.push_back({sof, eof, d}); else q_main.push_back({sof, eof, d});
        end
        done = 1;
      end else if (++t > 3000) begin
        tests++; fails++;
        $display("FAIL in_ready_timeout: lane=%0d in_ready stayed 0, required 1", sel);
        done = 1;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0; s_in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_frame(input bit sel, input int n, input logic [7:0] key);
    for (int i = 0; i < n; i++)
      send_sym(sel, 8'(i) ^ key, i == 0, 1'b1, i, 1'b1, i == n - 1);
  endtask

  task automatic wait_drain(input bit sel, input int budget);
    int t = 0;
    while ((sel ? q_small.size() : q_main.size()) != 0 && t < budget) begin
      @(posedge clock); #1; t++;
    end
    tests++;
    if (t >= budget) begin
      fails++; $display("FAIL drain_timeout: lane=%0d pending=%0d required 0", sel, sel ? q_small.size() : q_main.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clock);
    tests++;
    if ({out_valid, out_sof, out_eof, frame_err, ram_wren, ram_rden, s_out_valid, s_ram_wren, s_ram_rden} !== 9'b0 ||
        {out_data, ram_data, ram_wraddress, ram_rdaddress} !== 32'b0) begin
      fails++;
      $display("FAIL %s_outputs: valid=%b wren=%b rden=%b data=%h rdaddr=%0d required all 0",
               tag, out_valid, ram_wren, ram_rden, out_data, ram_rdaddress);
    end
    tests++;
    if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
      fails++; $display("FAIL %s_in_ready: in_ready=%b/%b required 1/1", tag, in_ready, s_in_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    do_reset();
    check_idle_outputs("reset");
  endtask

  task automatic test_single_frame();
    int r0 = rx_main;
    out_ready = 1'b1;
    send_frame(0, N, 8'h5A);
    @(negedge clock);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL full_after_frame: in_ready=%b required 0", in_ready); end
    @(posedge clock); #1;
    wait_drain(0, 2000);
    tests++;
    if (rx_main - r0 != N) begin fails++; $display("FAIL single_count: got %0d symbols required %0d", rx_main - r0, N); end
  endtask

  task automatic test_hold();
    int  r0;
    int  t = 0;
    bit  bad = 0;
    out_ready = 1'b0;
    send_frame(0, N, 8'h33);
    r0 = rden_main;
    repeat (10) begin
      @(negedge clock);
      if (in_ready !== 1'b0) bad = 1;
    end
    tests++;
    if (bad) begin fails++; $display("FAIL hold_in_ready: in_ready rose while held, required 0"); end
    tests++;
    if (rden_main != r0) begin fails++; $display("FAIL hold_no_rden: %0d reads issued required 0", rden_main - r0); end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    while (in_ready !== 1'b1 && t < 100) begin @(negedge clock); t++; end
    tests++;
    if (ram_rden !== 1'b1 || ram_rdaddress !== 8'd1) begin
      fails++; $display("FAIL hold_first_ready: rden=%b rdaddress=%0d required 1/1", ram_rden, ram_rdaddress);
    end
    @(posedge clock); #1;
    send_frame(0, N, 8'hC3);
    wait_drain(0, 3000);
  endtask

  task automatic test_back_to_back();
    int r0 = rx_main;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_frame(0, N, 8'(k * 37 + 1));
    wait_drain(0, 3000);
    tests++;
    if (rx_main - r0 != 4 * N) begin fails++; $display("FAIL b2b_count: got %0d symbols required %0d", rx_main - r0, 4 * N); end
  endtask

  task automatic test_framing();
    int e0;
    do_reset();
    out_ready = 1'b1;
    e0 = err_main;
    send_sym(0, 8'h11, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if (err_main != e0 + 1) begin fails++; $display("FAIL no_sof_err: %0d pulses required 1", err_main - e0); end
    for (int i = 0; i < 100; i++) send_sym(0, 8'(i), i == 0, 1'b1, i, 1'b0, 1'b0);
    send_sym(0, 8'hEE, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    for (int i = 1; i < N; i++) send_sym(0, 8'(i) ^ 8'h77, 1'b0, 1'b1, i, 1'b1, i == N - 1);
    @(negedge clock);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL resync_full: in_ready=%b required 0", in_ready); end
    tests++;
    if (err_main != e0 + 2) begin fails++; $display("FAIL resync_err: %0d pulses required 2", err_main - e0); end
    @(posedge clock); #1;
    wait_drain(0, 2000);
  endtask

  task automatic test_reset_mid_read();
    int r0;
    int t = 0;
    out_ready = 1'b1;
    send_frame(0, N, 8'h99);
    @(negedge clock);
    while (!(ram_rden === 1'b1 && ram_rdaddress === 8'd36) && t < 500) begin @(negedge clock); t++; end
    tests++;
    if (t >= 500) begin fails++; $display("FAIL mid_read_timeout: address 36 never issued, required issue"); end
    @(posedge clock); #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    check_idle_outputs("mid_reset");
    r0 = rx_main;
    repeat (300) @(posedge clock);
    #1;
    tests++;
    if (rx_main != r0) begin fails++; $display("FAIL stale_frame: %0d symbols out after reset required 0", rx_main - r0); end
    send_frame(0, N, 8'h42);
    wait_drain(0, 2000);
  endtask

  task automatic test_random_ready();
    int r0 = rx_small;
    rand_en = 1;
    for (int k = 0; k < 6; k++) send_frame(1, NS, 8'(k * 16 + 3));
    wait_drain(1, 2000);
    rand_en = 0;
    tests++;
    if (rx_small - r0 != 6 * NS) begin
      fails++; $display("FAIL random_count: got %0d symbols required %0d", rx_small - r0, 6 * NS);
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; s_out_ready = 1'b0;
    @(posedge clock); #1;
    test_reset();
    test_single_frame();
    test_hold();
    test_back_to_back();
    test_framing();
    test_reset_mid_read();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
